// File: rtl/stage_sequencer_pkg.sv
// Shared constants for the multi-cycle CPU stage sequencer: state encodings,
// stage count, default counter width and the state-to-valid decode.
package stage_sequencer_pkg;

  localparam int NUM_STAGES    = 5;
  localparam int DEFAULT_CNT_W = 32;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_IF   = 3'd1;
  localparam logic [2:0] ST_ID   = 3'd2;
  localparam logic [2:0] ST_EXE  = 3'd3;
  localparam logic [2:0] ST_MEM  = 3'd4;
  localparam logic [2:0] ST_WB   = 3'd5;

  // Bit order is {WB, MEM, EXE, ID, IF}; IDLE and illegal codes give all zeros.
  function automatic logic [NUM_STAGES-1:0] validOneHot(input logic [2:0] st);
    logic [NUM_STAGES-1:0] v;
    v = '0;
    case (st)
      ST_IF:   v = 5'b00001;
      ST_ID:   v = 5'b00010;
      ST_EXE:  v = 5'b00100;
      ST_MEM:  v = 5'b01000;
      ST_WB:   v = 5'b10000;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-state cycle counter with a sticky hang flag; fires once a stage has held
// its valid for TIMEOUT cycles. Only instantiated under STAGE_TIMEOUT_EN.
module stage_watchdog
  import stage_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] i_state,
  output logic       o_timeout,
  output logic       o_hang
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [2:0]    r_prevState;
  logic [CW-1:0] r_cnt;
  logic          r_hang;
  logic [CW-1:0] w_held;
  logic          w_fire;

  // w_held is the number of earlier cycles spent in the present state.
  assign w_held = (i_state == r_prevState) ? r_cnt : '0;
  assign w_fire = (i_state != ST_IDLE) && !r_hang && (w_held == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_prevState <= ST_IDLE;
      r_cnt       <= '0;
      r_hang      <= 1'b0;
    end else begin
      r_prevState <= i_state;
      r_hang      <= r_hang | w_fire;
      if (w_held != CW'(TIMEOUT))
        r_cnt <= w_held + CW'(1);
      else
        r_cnt <= w_held;
    end
  end

  assign o_timeout = w_fire;
  assign o_hang    = r_hang;

endmodule

// File: rtl/stage_sequencer.sv
// Control FSM of the multi-cycle CPU: one-hot IF/ID/EXE/MEM/WB valids, next_fetch
// pulse and retired-instruction counter. Define STAGE_TIMEOUT_EN for the stage watchdog.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
`ifdef STAGE_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             IF_over,
  input  logic             ID_over,
  input  logic             EXE_over,
  input  logic             MEM_over,
  input  logic             WB_over,
  input  logic             cancel,
  output logic             IF_valid,
  output logic             ID_valid,
  output logic             EXE_valid,
  output logic             MEM_valid,
  output logic             WB_valid,
  output logic             next_fetch,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] inst_count
`ifdef STAGE_TIMEOUT_EN
  ,
  output logic             hang
`endif
);

  logic [2:0]            r_state;
  logic [NUM_STAGES-1:0] r_valid;
  logic                  r_nextFetch;
  logic [CNT_W-1:0]      r_instCount;

  logic [2:0] w_nextState;
  logic       w_nextFetch;
  logic       w_retire;
  logic       w_stageOver;
  logic       w_timeout;
  logic       w_hold;

`ifdef STAGE_TIMEOUT_EN
  stage_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .resetn    (resetn),
    .i_state   (r_state),
    .o_timeout (w_timeout),
    .o_hang    (w_hold)
  );
  assign hang = w_hold;
`else
  assign w_timeout = 1'b0;
  assign w_hold    = 1'b0;
`endif

  // Only the active stage's over is looked at, so a lagging IF_over is harmless.
  always_comb begin
    w_stageOver = 1'b0;
    case (r_state)
      ST_IF:   w_stageOver = IF_over;
      ST_ID:   w_stageOver = ID_over;
      ST_EXE:  w_stageOver = EXE_over;
      ST_MEM:  w_stageOver = MEM_over;
      ST_WB:   w_stageOver = WB_over;
      default: w_stageOver = 1'b0;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    w_nextFetch = 1'b0;
    w_retire    = 1'b0;
    if (w_timeout) begin
      w_nextState = ST_IDLE;
    end else if (r_state == ST_IDLE) begin
      if (!w_hold)
        w_nextState = ST_IF;
    end else if (r_state > ST_WB) begin
      w_nextState = ST_IDLE;
    end else if (cancel) begin
      w_nextState = ST_IF;
      w_nextFetch = 1'b1;
    end else if (w_stageOver) begin
      if (r_state == ST_WB) begin
        w_nextState = ST_IF;
        w_nextFetch = 1'b1;
        w_retire    = 1'b1;
      end else begin
        w_nextState = r_state + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_valid     <= '0;
      r_nextFetch <= 1'b0;
      r_instCount <= '0;
    end else begin
      r_state     <= w_nextState;
      r_valid     <= validOneHot(w_nextState);
      r_nextFetch <= w_nextFetch;
      if (w_retire)
        r_instCount <= r_instCount + CNT_W'(1);
    end
  end

  assign IF_valid   = r_valid[0];
  assign ID_valid   = r_valid[1];
  assign EXE_valid  = r_valid[2];
  assign MEM_valid  = r_valid[3];
  assign WB_valid   = r_valid[4];
  assign next_fetch = r_nextFetch;
  assign state      = r_state;
  assign inst_count = r_instCount;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: directed steps plus random over/cancel
// traffic against a stage-index reference model. Honours STAGE_TIMEOUT_EN.
module tb_stage_sequencer;

  logic       clk;
  logic       resetn;
  logic       IF_over, ID_over, EXE_over, MEM_over, WB_over;
  logic       cancel;
  logic       IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid;
  logic       next_fetch;
  logic [2:0] state;
  logic [3:0] inst_count;
`ifdef STAGE_TIMEOUT_EN
  logic       hang;
  localparam int TIMEOUT_M = 16;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: stage index 0=idle, 1..5 = IF..WB
  int mStage = 0;
  int mCount = 0;
  int mHeld  = 0;
  bit mNf    = 1'b0;
  bit mHang  = 1'b0;
  int ifLag  = 0;

  stage_sequencer #(
    .CNT_W (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .IF_over    (IF_over),
    .ID_over    (ID_over),
    .EXE_over   (EXE_over),
    .MEM_over   (MEM_over),
    .WB_over    (WB_over),
    .cancel     (cancel),
    .IF_valid   (IF_valid),
    .ID_valid   (ID_valid),
    .EXE_valid  (EXE_valid),
    .MEM_valid  (MEM_valid),
    .WB_valid   (WB_valid),
    .next_fetch (next_fetch),
    .state      (state),
    .inst_count (inst_count)
`ifdef STAGE_TIMEOUT_EN
    ,
    .hang       (hang)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkModel();
    logic [4:0] ev;
    ev = '0;
    if (mStage > 0) ev[mStage-1] = 1'b1;
    checkOutput("state", {29'd0, state}, mStage);
    checkOutput("valids", {27'd0, WB_valid, MEM_valid, EXE_valid, ID_valid, IF_valid}, {27'd0, ev});
    checkOutput("next_fetch", {31'd0, next_fetch}, {31'd0, mNf});
    checkOutput("inst_count", {28'd0, inst_count}, mCount);
`ifdef STAGE_TIMEOUT_EN
    checkOutput("hang", {31'd0, hang}, {31'd0, mHang});
`endif
  endtask

  // Drives one cycle of inputs, advances the model by the same edge, then checks.
  task automatic applyStimulus(input bit rstN, input bit cxl, input bit [4:0] overs);
    int prev;
    int ns;
    bit fire;
    prev = mStage;
    resetn = rstN;
    cancel = cxl;
    {WB_over, MEM_over, EXE_over, ID_over, IF_over} = overs;
    fire = 1'b0;
`ifdef STAGE_TIMEOUT_EN
    fire = (mStage != 0) && !mHang && (mHeld == TIMEOUT_M);
`endif
    if (!rstN) begin
      ns = 0; mCount = 0; mNf = 1'b0; mHang = 1'b0;
    end else begin
      ns = mStage;
      mNf = 1'b0;
      if (fire) begin
        ns = 0;
        mHang = 1'b1;
      end else if (mStage == 0) begin
        ns = mHang ? 0 : 1;
      end else if (cxl) begin
        ns = 1;
        mNf = 1'b1;
      end else if (overs[mStage-1]) begin
        if (mStage == 5) begin
          ns = 1;
          mNf = 1'b1;
          mCount = (mCount + 1) % 16;
        end else begin
          ns = mStage + 1;
        end
      end
    end
    mHeld = (!rstN || ns != mStage) ? 0 : mHeld + 1;
    mStage = ns;
    @(posedge clk);
    #1;
    checkModel();
    if (prev == 1 && mStage != 1) ifLag = 2;
    else if (ifLag > 0) ifLag--;
  endtask

  task automatic advanceTo(input int target);
    int guard;
    guard = 0;
    while (mStage != target && guard < 20) begin
      bit [4:0] ov;
      ov = '0;
      if (mStage > 0) ov[mStage-1] = 1'b1;
      if (ifLag > 0) ov[0] = 1'b1;
      applyStimulus(1'b1, 1'b0, ov);
      guard++;
    end
    checkOutput("advanceTo", {29'd0, state}, target);
  endtask

  // Fetch ROM answers on the second IF cycle; other stages finish at once.
  task automatic driveRom(input int n);
    for (int i = 0; i < n; i++) begin
      bit [4:0] ov;
      ov = '0;
      if (mStage == 1 && mHeld >= 1) ov[0] = 1'b1;
      if (mStage >= 2) ov[mStage-1] = 1'b1;
      if (ifLag > 0) ov[0] = 1'b1;
      applyStimulus(1'b1, 1'b0, ov);
    end
  endtask

  task automatic driveRandom(input int n);
    for (int i = 0; i < n; i++) begin
      bit [4:0] ov;
      bit rs;
      bit cx;
      ov = 5'($urandom);
      if (mStage > 0) ov[mStage-1] = ($urandom_range(0, 2) == 0);
      if (ifLag > 0) ov[0] = 1'b1;
      cx = ($urandom_range(0, 99) < 5);
      rs = ($urandom_range(0, 199) != 0);
      applyStimulus(rs, cx, ov);
    end
  endtask

  initial begin
    resetn = 1'b0; cancel = 1'b0;
    IF_over = 1'b0; ID_over = 1'b0; EXE_over = 1'b0; MEM_over = 1'b0; WB_over = 1'b0;

    // Reset state, then one instruction through the ROM-timed stages
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 5'b00000);
    driveRom(9);

    // Stale IF_over in ID must not move the FSM
    advanceTo(2);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 5'b00001);
    applyStimulus(1'b1, 1'b0, 5'b00010);

    // Cancel with EXE_over, then cancel with WB_over
    advanceTo(3);
    applyStimulus(1'b1, 1'b1, 5'b00100);
    applyStimulus(1'b1, 1'b0, 5'b00000);
    advanceTo(5);
    applyStimulus(1'b1, 1'b1, 5'b10000);
    applyStimulus(1'b1, 1'b0, 5'b00000);

    // Cancel in IDLE is ignored
    applyStimulus(1'b0, 1'b0, 5'b00000);
    applyStimulus(1'b1, 1'b1, 5'b11111);
    applyStimulus(1'b1, 1'b0, 5'b00000);

    // 17 instructions to wrap the 4-bit counter
    for (int i = 0; i < 17; i++) begin
      advanceTo(5);
      applyStimulus(1'b1, 1'b0, 5'b10000);
    end

    // Reset in MEM with MEM_over pending
    advanceTo(4);
    applyStimulus(1'b0, 1'b0, 5'b01000);
    applyStimulus(1'b1, 1'b0, 5'b00000);

    driveRandom(600);

`ifdef STAGE_TIMEOUT_EN
    applyStimulus(1'b0, 1'b0, 5'b00000);
    advanceTo(4);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 5'b10111);
    applyStimulus(1'b1, 1'b1, 5'b11111);
    applyStimulus(1'b0, 1'b0, 5'b00000);
    applyStimulus(1'b1, 1'b0, 5'b00000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
